// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch request handshake between the PC generator and instruction fetch
//   fetch_valid  PC generator -> fetch : fetch_pc is a valid request
//   fetch_ready  fetch -> PC generator : request accepted this cycle
//   fetch_pc     PC generator -> fetch : current PC
interface pc_unit_if #(
   parameter int LENGTH = 32
);
   logic              fetch_valid;
   logic              fetch_ready;
   logic [LENGTH-1:0] fetch_pc;
   modport master (output fetch_valid, output fetch_pc, input fetch_ready);
   modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_unit.sv
// pc_unit: parametrised program-counter generator with boot/run/halt control and prioritised redirects
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   fetch          master side of the fetch handshake (fetch_valid, fetch_pc out; fetch_ready in)
//   stall          freezes sequential advance
//   branch_taken   redirect to branch_target
//   exc / exc_pc   exception: jump to EXC_VECTOR, save exc_pc in epc
//   eret           return to epc
//   halt / resume  enter / leave HALT
//   epc            saved exception PC
//   fetch_count    accepted fetches, wraps
//   misalign       sticky misaligned-target flag, only with PC_MISALIGN_CHECK_EN defined (else 0)
module pc_unit #(
   parameter int                LENGTH     = 32,
   parameter logic [LENGTH-1:0] STEP       = LENGTH'(4),
   parameter logic [LENGTH-1:0] RESET_PC   = '0,
   parameter logic [LENGTH-1:0] EXC_VECTOR = LENGTH'('h2000)
) (
   input  logic              clk,
   input  logic              reset,
   pc_unit_if.master         fetch,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [LENGTH-1:0] branch_target,
   input  logic              exc,
   input  logic [LENGTH-1:0] exc_pc,
   input  logic              eret,
   input  logic              halt,
   input  logic              resume,
   output logic [LENGTH-1:0] epc,
   output logic [LENGTH-1:0] fetch_count,
   output logic              misalign
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t            state;
   logic              valid;
   logic [LENGTH-1:0] pc;
   logic              accept;
   logic [LENGTH-1:0] target;
   assign accept            = valid & fetch.fetch_ready;
   assign target            = eret ? epc : branch_target;
   assign fetch.fetch_valid = valid;
   assign fetch.fetch_pc    = pc;
`ifndef PC_MISALIGN_CHECK_EN
   assign misalign = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         valid       <= 1'b0;
         pc          <= RESET_PC;
         epc         <= '0;
         fetch_count <= '0;
`ifdef PC_MISALIGN_CHECK_EN
         misalign    <= 1'b0;
`endif
      end else begin
         if (accept) fetch_count <= fetch_count + LENGTH'(1);
         if (state == BOOT) begin
            state <= RUN;
            valid <= 1'b1;
         end else if (exc) begin
            pc    <= EXC_VECTOR;
            epc   <= exc_pc;
            state <= RUN;
            valid <= 1'b1;
         end else if (state == HALT) begin
            // fetch_pc holds in HALT; only resume (or exc above) leaves it
            if (resume) begin
               state <= RUN;
               valid <= 1'b1;
            end
         end else if (eret || branch_taken) begin
`ifdef PC_MISALIGN_CHECK_EN
            // a target off the STEP grid traps instead of being fetched
            if (|(target & (STEP - LENGTH'(1)))) begin
               pc       <= EXC_VECTOR;
               epc      <= target;
               misalign <= 1'b1;
            end else pc <= target;
`else
            pc <= target;
`endif
         end else begin
            // halt only takes effect without a redirect; the increment of this cycle still lands
            if (accept && !stall) pc <= pc + STEP;
            if (halt) begin
               state <= HALT;
               valid <= 1'b0;
            end
         end
      end
   end
endmodule
